load_store_unit: RTL and testbench
==================================

# load_store_unit

Core-side initiator for the byte-addressed, little-endian data memory port. Accepts one load or store per handshake from the execute stage, decodes RV32I funct3 into byte-lane write enables and a word-aligned address, and drives the memory's `address`/`dwdata`/`we` inputs. It samples the memory's combinational read data, aligns it, and sign- or zero-extends it. Each result is returned to writeback through a single-cycle response strobe.

## Interface
- No parameters (memory port fixed at 32-bit address / 32-bit data / 4 byte lanes).
- `clk`  in  1  clock; memory writes on the same rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept; high only in IDLE.
- `req_store`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I funct3: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-justified.
- `rsp_valid`  out  1  one-cycle response strobe.
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors.
- `rsp_err`  out  1  illegal funct3 or unsupported misaligned access; qualified by `rsp_valid`.
- `mem_addr`  out  32  word-aligned address (bits [1:0] always 0).
- `mem_wdata`  out  32  lane-positioned store data.
- `mem_we`  out  4  byte-lane write enables, bit i = byte i.
- `mem_rdata`  in  32  combinational read of `mem_addr`.

## Operation
- States: IDLE, ACC0, ACC1, RESP.
- IDLE: `req_ready`=1. On `req_valid`, capture the request and go to ACC0, or directly to RESP with `rsp_err`=1 if the request is illegal.
- Illegal requests:
  - load funct3 011, 110 or 111;
  - store funct3 with bit 2 set, or 011.
- Size: bytes = 1/2/4 from funct3[1:0]. Offset = addr[1:0]. Crossing = offset + size > 4.
- Lane mask: 8-bit value = (size mask) << offset. The low nibble is the ACC0 `we`; the high nibble is the ACC1 `we`.
- Store data: 64-bit value = (size-masked wdata) << (8·offset). The low word goes to ACC0; the high word goes to ACC1.
- ACC0:
  - `mem_addr` = addr & ~3; `mem_we` = low lanes (stores only);
  - `mem_rdata` is latched at the end of the cycle;
  - next state is ACC1 if crossing, else RESP.
- ACC1: `mem_addr` = (addr & ~3) + 4, wrapping modulo 2^32; `mem_we` = high lanes; latch the upper read word. Next state is RESP.
- RESP:
  - `rsp_valid`=1;
  - loads: the 64-bit {hi, lo} read value >> (8·offset), truncated to size, then sign-extended (LB/LH) or zero-extended (LBU/LHU/LW);
  - next state is IDLE.
- Non-crossing misaligned accesses (e.g. LH at offset 1, SB anywhere) are legal and use ACC0 only.
- `mem_we` = 0 in IDLE and RESP, and is forced to 0 combinationally whenever `rst`=1.
- Split store interrupted by reset after ACC0: the first word stays written. This is a documented partial store.

## Timing
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0, `mem_addr`=0, `mem_wdata`=0, `mem_we`=0.
- Accept at edge N:
  - aligned or non-crossing: memory access in cycle N+1, `rsp_valid` in cycle N+2;
  - crossing: accesses in N+1 and N+2, response in N+3;
  - illegal: response in N+1.
- Throughput: one request per 3 cycles (4 if crossing). `req_ready` is low from ACC0 through RESP inclusive.
- A store's bytes are committed at the rising edge ending each ACC cycle.
- Outputs `mem_*` and `rsp_*` are decoded from registered state and captured request only, with no combinational path from `req_*`. The one exception is `rst` gating of `mem_we`.

## Configuration
- `LSU_MISALIGNED_SPLIT_EN` defined: crossing accesses are split over ACC0/ACC1 as above.
- Not defined: a crossing access performs no memory cycle and responds in N+1 with `rsp_err`=1, `rsp_rdata`=0, `mem_we` never asserted. ACC1 logic is absent.

## Structure
- `lsu_pkg`: funct3 localparams (LB…SW), state enum, size-to-mask function.
- Sub-module `lsu_lane_align`: purely combinational.
  - Inputs: offset, funct3, store data, {hi, lo} read word.
  - Outputs: 8-bit lane mask, 64-bit positioned write data, extended load result.
- The FSM and capture registers live in `load_store_unit`.

## Test plan
- Memory word 0x100 = 0x8899AABB. LB @0x101 -> `mem_addr`=0x100 in N+1, `rsp_rdata`=0xFFFFFFAA in N+2. LBU @0x101 -> 0x000000AA.
- SH wdata 0x12345678 @0x102 -> `mem_we`=1100, `mem_wdata`[31:16]=0x5678; the word becomes 0x5678AABB.
- Words 0x100=0x44332211, 0x104=0x88776655 (macro on). LW @0x103 -> accesses 0x100 then 0x104, `rsp_rdata`=0x77665544 in N+3.
- Same LW @0x103 with the macro off -> `rsp_err`=1, `rsp_rdata`=0 in N+1, `mem_we` stays 0.
- Load funct3=011 or store funct3=100 -> `rsp_err`=1 in N+1, no memory write.
- Reset asserted during ACC0 of SW @0x200 -> `mem_we`=0 that cycle, word unchanged. Next cycle: IDLE, `rsp_valid`=0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, the FSM
// state type and the size/legality helpers used at request acceptance.
package lsu_pkg;

    // Load encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    // Store encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    // Byte-lane mask for an access of the given size code, at offset 0.
    function automatic logic [3:0] size_mask(input logic [1:0] size_code);
        case (size_code)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Access size in bytes (1/2/4) for the given size code.
    function automatic logic [2:0] size_bytes(input logic [1:0] size_code);
        case (size_code)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Encodings that do not name a supported access.
    function automatic logic is_illegal(input logic store, input logic [2:0] funct3);
        if (store)
            return funct3[2] || (funct3[1:0] == 2'b11);
        else
            return (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    endfunction

    // True when the access spills past the end of its aligned word.
    function automatic logic is_crossing(input logic [1:0] offset, input logic [1:0] size_code);
        return ({1'b0, offset} + size_bytes(size_code)) > 3'd4;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Signal bundle between the load/store unit, the execute/writeback side and
// the data memory port. The master modport is the load/store unit itself; the
// slave modport is its environment (core pipeline plus memory).
interface lsu_if;
    // Request from execute
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    // Response to writeback
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    // Data memory port
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_we;
    logic [31:0] mem_rdata;

    modport master (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_we
    );

    modport slave (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Purely combinational byte-lane alignment: positions store data and its
// lane mask across a 64-bit two-word window, and extracts/extends load data
// from the {hi, lo} read window.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    input  logic [31:0] store_data,
    input  logic [63:0] read_data,
    output logic [7:0]  lane_mask,
    output logic [63:0] write_data,
    output logic [31:0] load_data
);

    logic [5:0]  bit_shift;
    logic [31:0] store_sized;
    logic [31:0] read_window;

    // Shift store data/mask up by the byte offset and pull load data down by it
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path through the case statements can leave a latch behind.
        store_sized = store_data;
        load_data   = '0;

        bit_shift   = {1'b0, offset, 3'b000};
        lane_mask   = {4'b0000, size_mask(funct3[1:0])} << offset;

        case (funct3[1:0])
            2'b00:   store_sized = {24'b0, store_data[7:0]};
            2'b01:   store_sized = {16'b0, store_data[15:0]};
            default: store_sized = store_data;
        endcase
        write_data  = {32'b0, store_sized} << bit_shift;

        read_window = 32'(read_data >> bit_shift);
        case (funct3)
            F3_LB:   load_data = {{24{read_window[7]}}, read_window[7:0]};
            F3_LH:   load_data = {{16{read_window[15]}}, read_window[15:0]};
            F3_LW:   load_data = read_window;
            F3_LBU:  load_data = {24'b0, read_window[7:0]};
            F3_LHU:  load_data = {16'b0, read_window[15:0]};
            default: load_data = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one load or store per handshake, drives the
// word-addressed data memory port with byte-lane enables, and returns the
// aligned, extended load result through a single-cycle response strobe.
// Optional feature: define LSU_MISALIGNED_SPLIT_EN to split word-crossing
// accesses over two memory cycles (ACC0/ACC1); otherwise they are rejected
// with rsp_err.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    lsu_if.master bus
);

    lsu_state_e  state;
    lsu_state_e  state_next;

    // Captured request and latched read data
    logic        cap_store;
    logic [2:0]  cap_funct3;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic        cap_err;
    logic [31:0] rdata_lo;
`ifdef LSU_MISALIGNED_SPLIT_EN
    logic        cap_cross;
    logic [31:0] rdata_hi;
`endif

    logic        accept;
    logic        req_bad;
    logic [31:0] word_addr;
    logic [63:0] read_data;
    logic [7:0]  lane_mask;
    logic [63:0] write_data;
    logic [31:0] load_data;

    assign accept    = (state == IDLE) && bus.req_valid;
    assign word_addr = {cap_addr[31:2], 2'b00};

`ifdef LSU_MISALIGNED_SPLIT_EN
    assign read_data = {rdata_hi, rdata_lo};
`else
    assign read_data = {32'b0, rdata_lo};

    // The upper half of the alignment window only matters for split accesses
    logic unused_hi;
    assign unused_hi = ^{lane_mask[7:4], write_data[63:32]};
`endif

    lsu_lane_align u_align (
        .offset     (cap_addr[1:0]),
        .funct3     (cap_funct3),
        .store_data (cap_wdata),
        .read_data  (read_data),
        .lane_mask  (lane_mask),
        .write_data (write_data),
        .load_data  (load_data)
    );

    // Decide at acceptance whether the request goes straight to an error response
    always_comb begin
        req_bad = is_illegal(bus.req_store, bus.req_funct3);
`ifndef LSU_MISALIGNED_SPLIT_EN
        if (is_crossing(bus.req_addr[1:0], bus.req_funct3[1:0]))
            req_bad = 1'b1;
`endif
    end

    // FSM state register
    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with non-blocking assignments so
        // every register samples pre-edge values regardless of block order.
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.req_valid) state_next = req_bad ? RESP : ACC0;
`ifdef LSU_MISALIGNED_SPLIT_EN
            ACC0: state_next = cap_cross ? ACC1 : RESP;
            ACC1: state_next = RESP;
`else
            ACC0: state_next = RESP;
`endif
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request capture and read-data latching
    always_ff @(posedge clk) begin
        // NOTE: the capture/data registers are reset too; they feed outputs
        // only through state decode, but a known value keeps rsp_rdata and the
        // read window free of stale data after reset.
        if (rst) begin
            cap_store  <= 1'b0;
            cap_funct3 <= '0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            cap_err    <= 1'b0;
            rdata_lo   <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
            cap_cross  <= 1'b0;
            rdata_hi   <= '0;
`endif
        end else begin
            if (accept) begin
                cap_store  <= bus.req_store;
                cap_funct3 <= bus.req_funct3;
                cap_addr   <= bus.req_addr;
                cap_wdata  <= bus.req_wdata;
                cap_err    <= req_bad;
                rdata_lo   <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
                cap_cross  <= is_crossing(bus.req_addr[1:0], bus.req_funct3[1:0]);
                rdata_hi   <= '0;
`endif
            end
            if (state == ACC0)
                rdata_lo <= bus.mem_rdata;
`ifdef LSU_MISALIGNED_SPLIT_EN
            if (state == ACC1)
                rdata_hi <= bus.mem_rdata;
`endif
        end
    end

    // Output decode from registered state and captured request only
    always_comb begin
        bus.req_ready = (state == IDLE);
        bus.rsp_valid = 1'b0;
        bus.rsp_err   = 1'b0;
        bus.rsp_rdata = '0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_we    = '0;
        case (state)
            ACC0: begin
                bus.mem_addr = word_addr;
                if (cap_store) begin
                    bus.mem_wdata = write_data[31:0];
                    bus.mem_we    = lane_mask[3:0];
                end
            end
`ifdef LSU_MISALIGNED_SPLIT_EN
            ACC1: begin
                bus.mem_addr = word_addr + 32'd4;
                if (cap_store) begin
                    bus.mem_wdata = write_data[63:32];
                    bus.mem_we    = lane_mask[7:4];
                end
            end
`endif
            RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_err   = cap_err;
                if (!cap_store && !cap_err)
                    bus.rsp_rdata = load_data;
            end
            default: ;
        endcase
        // Reset must never let a half-finished store reach memory
        if (rst)
            bus.mem_we = '0;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a small word memory model answers
// the memory port, directed requests push their expected responses into a
// scoreboard queue, and a negedge monitor pops and compares every response.
`timescale 1ns/1ps
module tb_load_store_unit;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_if lsu_bus ();

    load_store_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (lsu_bus)
    );

    // Memory model: 256 words, combinational read, byte-lane writes on the edge
    logic [31:0] mem [0:255];
    logic        poke_en   = 1'b0;
    logic [7:0]  poke_idx  = '0;
    logic [31:0] poke_data = '0;
    int          we_edges  = 0;

    always_comb lsu_bus.mem_rdata = mem[lsu_bus.mem_addr[9:2]];

    always @(posedge clk) begin
        if (poke_en)
            mem[poke_idx] <= poke_data;
        else
            for (int i = 0; i < 4; i++)
                if (lsu_bus.mem_we[i])
                    mem[lsu_bus.mem_addr[9:2]][8*i +: 8] <= lsu_bus.mem_wdata[8*i +: 8];
        if (lsu_bus.mem_we != 4'b0000)
            we_edges <= we_edges + 1;
    end

    // Scoreboard
    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Response monitor
    always @(negedge clk) begin
        rsp_t e;
        if (lsu_bus.rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("rsp_err", 32'(lsu_bus.rsp_err), 32'(e.err));
                check("rsp_rdata", lsu_bus.rsp_rdata, e.rdata);
            end
        end
    end

    task automatic poke(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        poke_en   = 1'b1;
        poke_idx  = addr[9:2];
        poke_data = data;
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    // Issue one request; returns 1 ns after the accepting edge (cycle N+1)
    task automatic send(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic want_rsp,
                        input logic exp_err, input logic [31:0] exp_rdata);
        int waited;
        waited = 0;
        @(negedge clk);
        while (lsu_bus.req_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("req_ready_idle", 32'(lsu_bus.req_ready), 32'd1);
        if (want_rsp)
            exp_q.push_back({exp_err, exp_rdata});
        lsu_bus.req_valid  = 1'b1;
        lsu_bus.req_store  = st;
        lsu_bus.req_funct3 = f3;
        lsu_bus.req_addr   = addr;
        lsu_bus.req_wdata  = wdata;
        @(posedge clk);
        #1 lsu_bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("rsp_drain", 32'(exp_q.size()), 32'd0);
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] exp;
    } load_vec_t;

    load_vec_t loads [6];
    int        we_base;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks so far %0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        lsu_bus.req_valid  = 1'b0;
        lsu_bus.req_store  = 1'b0;
        lsu_bus.req_funct3 = '0;
        lsu_bus.req_addr   = '0;
        lsu_bus.req_wdata  = '0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(lsu_bus.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(lsu_bus.rsp_valid), 32'd0);
        check("rst_rsp_err",   32'(lsu_bus.rsp_err),   32'd0);
        check("rst_rsp_rdata", lsu_bus.rsp_rdata,      32'd0);
        check("rst_mem_addr",  lsu_bus.mem_addr,       32'd0);
        check("rst_mem_wdata", lsu_bus.mem_wdata,      32'd0);
        check("rst_mem_we",    32'(lsu_bus.mem_we),    32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // LB / LBU at offset 1 of 0x8899AABB
        poke(32'h100, 32'h8899AABB);
        send(1'b0, F3_LB, 32'h101, 32'h0, 1'b1, 1'b0, 32'hFFFFFFAA);
        @(negedge clk);
        check("lb_mem_addr_n1", lsu_bus.mem_addr, 32'h100);
        check("lb_mem_we_n1", 32'(lsu_bus.mem_we), 32'h0);
        check("lb_ready_low_n1", 32'(lsu_bus.req_ready), 32'd0);
        @(negedge clk);
        check("lb_rsp_valid_n2", 32'(lsu_bus.rsp_valid), 32'd1);
        drain();
        send(1'b0, F3_LBU, 32'h101, 32'h0, 1'b1, 1'b0, 32'h000000AA);
        drain();

        // SH at offset 2: upper two lanes
        send(1'b1, F3_SH, 32'h102, 32'h12345678, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check("sh_mem_addr", lsu_bus.mem_addr, 32'h100);
        check("sh_mem_we", 32'(lsu_bus.mem_we), 32'hC);
        check("sh_mem_wdata_hi", 32'(lsu_bus.mem_wdata[31:16]), 32'h5678);
        drain();
        check("sh_word", mem[8'h40], 32'h5678AABB);

        // Loads from 0x5678AABB, including non-crossing misaligned halfword
        loads[0] = '{F3_LH,  32'h101, 32'h000078AA};
        loads[1] = '{F3_LB,  32'h100, 32'hFFFFFFBB};
        loads[2] = '{F3_LHU, 32'h100, 32'h0000AABB};
        loads[3] = '{F3_LH,  32'h100, 32'hFFFFAABB};
        loads[4] = '{F3_LW,  32'h100, 32'h5678AABB};
        loads[5] = '{F3_LB,  32'h103, 32'h00000056};
        for (int i = 0; i < 6; i++) begin
            send(1'b0, loads[i].f3, loads[i].addr, 32'h0, 1'b1, 1'b0, loads[i].exp);
            drain();
        end

        // Word-crossing accesses
        poke(32'h100, 32'h44332211);
        poke(32'h104, 32'h88776655);
        we_base = we_edges;
`ifdef LSU_MISALIGNED_SPLIT_EN
        send(1'b0, F3_LW, 32'h103, 32'h0, 1'b1, 1'b0, 32'h77665544);
        @(negedge clk);
        check("xlw_acc0_addr", lsu_bus.mem_addr, 32'h100);
        @(negedge clk);
        check("xlw_acc1_addr", lsu_bus.mem_addr, 32'h104);
        check("xlw_no_rsp_n2", 32'(lsu_bus.rsp_valid), 32'd0);
        @(negedge clk);
        check("xlw_rsp_valid_n3", 32'(lsu_bus.rsp_valid), 32'd1);
        drain();
        send(1'b1, F3_SW, 32'h102, 32'hDDCCBBAA, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check("xsw_acc0_we", 32'(lsu_bus.mem_we), 32'hC);
        check("xsw_acc0_wdata", lsu_bus.mem_wdata, 32'hBBAA0000);
        @(negedge clk);
        check("xsw_acc1_we", 32'(lsu_bus.mem_we), 32'h3);
        check("xsw_acc1_wdata", lsu_bus.mem_wdata, 32'h0000DDCC);
        drain();
        check("xsw_word_lo", mem[8'h40], 32'hBBAA2211);
        check("xsw_word_hi", mem[8'h41], 32'h8877DDCC);
`else
        send(1'b0, F3_LW, 32'h103, 32'h0, 1'b1, 1'b1, 32'h0);
        @(negedge clk);
        check("xlw_err_rsp_n1", 32'(lsu_bus.rsp_valid), 32'd1);
        check("xlw_err_no_we", 32'(lsu_bus.mem_we), 32'h0);
        drain();
        send(1'b1, F3_SW, 32'h102, 32'hDDCCBBAA, 1'b1, 1'b1, 32'h0);
        drain();
        check("xsw_no_write", 32'(we_edges), 32'(we_base));
        check("xsw_word_lo", mem[8'h40], 32'h44332211);
        check("xsw_word_hi", mem[8'h41], 32'h88776655);
`endif

        // Illegal encodings respond in N+1 with no memory write
        we_base = we_edges;
        send(1'b0, 3'b011, 32'h100, 32'h0, 1'b1, 1'b1, 32'h0);
        @(negedge clk);
        check("ill_load_rsp_n1", 32'(lsu_bus.rsp_valid), 32'd1);
        drain();
        send(1'b1, 3'b100, 32'h100, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0);
        @(negedge clk);
        check("ill_store_rsp_n1", 32'(lsu_bus.rsp_valid), 32'd1);
        drain();
        check("ill_no_write", 32'(we_edges), 32'(we_base));

        // Reset during ACC0 of a store: write suppressed, back to IDLE
        poke(32'h200, 32'hCAFEF00D);
        send(1'b1, F3_SW, 32'h200, 32'h11111111, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_acc0_we", 32'(lsu_bus.mem_we), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_after_rsp_valid", 32'(lsu_bus.rsp_valid), 32'd0);
        check("rst_after_ready", 32'(lsu_bus.req_ready), 32'd1);
        check("rst_word_kept", mem[8'h80], 32'hCAFEF00D);

        drain();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
